// File: rtl/alu_packet_ctrl.sv
// Packet sequencer between the UART byte streams and the shared 32-bit arithmetic unit.
// Define ALU_DIV_EN to accept opcode 0xD1 (divide); without it 0xD1 is drained as unknown.
module alu_packet_ctrl #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [1:0]        op_code_o,
    output logic [DATA_W-1:0] op_a_o,
    output logic [DATA_W-1:0] op_b_o,
    output logic              op_valid_o,
    input  logic              op_ready_i,
    input  logic [DATA_W-1:0] res_i,
    input  logic              res_valid_i,
    output logic              busy_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'h88;
`ifdef ALU_DIV_EN
    localparam logic [7:0] OP_DIV  = 8'hD1;
`endif

    typedef enum logic [3:0] {
        S_OPCODE,
        S_RESERVED,
        S_LENGTH_LSB,
        S_LENGTH_MSB,
        S_FIRST_NUMBER,
        S_RX_NUMBER,
        S_ISSUE,
        S_WAIT,
        S_ECHO,
        S_DRAIN,
        S_TRANSMIT
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          opcode_q, opcode_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                op_valid_q, op_valid_d;
    logic [1:0]          op_code_q, op_code_d;
    logic                started_q, started_d;

    logic                is_echo, is_arith;
    logic [1:0]          arith_code;
    logic                rx_fire, tx_fire, op_fire;
    logic [LEN_W-1:0]    full_len, payload, cnt_dec;
    logic [IDX_W-1:0]    idx_inc;
    logic                idx_last;
    logic [7:0]          acc_bytes [BYTES];

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_acc_bytes
            assign acc_bytes[gi] = acc_q[8*gi +: 8];
        end
    endgenerate

    // Where to go once a whole operand word has been folded in.
    function automatic state_t after_word(input logic [LEN_W-1:0] rem);
        if (rem >= LEN_W'(BYTES)) begin
            return S_RX_NUMBER;
        end else if (rem == '0) begin
            return S_TRANSMIT;
        end
        return S_DRAIN;
    endfunction

    always_comb begin
        is_echo    = (opcode_q == OP_ECHO);
        is_arith   = 1'b0;
        arith_code = 2'b00;
        case (opcode_q)
            OP_ADD: begin
                is_arith   = 1'b1;
                arith_code = 2'b00;
            end
            OP_MUL: begin
                is_arith   = 1'b1;
                arith_code = 2'b01;
            end
`ifdef ALU_DIV_EN
            OP_DIV: begin
                is_arith   = 1'b1;
                arith_code = 2'b10;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        rx_ready_o = 1'b0;
        case (state_q)
            S_OPCODE, S_RESERVED, S_LENGTH_LSB, S_LENGTH_MSB,
            S_FIRST_NUMBER, S_RX_NUMBER, S_DRAIN: rx_ready_o = started_q;
            S_ECHO:                               rx_ready_o = started_q & ~tx_valid_q;
            default:                              rx_ready_o = 1'b0;
        endcase
    end

    assign rx_fire  = rx_valid_i & rx_ready_o;
    assign tx_fire  = tx_valid_q & tx_ready_i;
    assign op_fire  = op_valid_q & op_ready_i;
    assign full_len = LEN_W'({rx_data_i, len_lo_q});
    assign payload  = (full_len >= LEN_W'(4)) ? full_len - LEN_W'(4) : '0;
    assign cnt_dec  = cnt_q - LEN_W'(1);
    assign idx_inc  = idx_q + IDX_W'(1);
    assign idx_last = (idx_q == IDX_W'(BYTES - 1));

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        len_lo_d   = len_lo_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        op_valid_d = op_valid_q;
        op_code_d  = op_code_q;
        started_d  = 1'b1;

        case (state_q)
            S_OPCODE: begin
                if (rx_fire) begin
                    opcode_d = rx_data_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = S_RESERVED;
                end
            end
            S_RESERVED: begin
                if (rx_fire) state_d = S_LENGTH_LSB;
            end
            S_LENGTH_LSB: begin
                if (rx_fire) begin
                    len_lo_d = rx_data_i;
                    state_d  = S_LENGTH_MSB;
                end
            end
            S_LENGTH_MSB: begin
                if (rx_fire) begin
                    cnt_d = payload;
                    idx_d = '0;
                    if (is_echo) begin
                        state_d = (payload == '0) ? S_OPCODE : S_ECHO;
                    end else if (is_arith) begin
                        op_code_d = arith_code;
                        state_d   = (payload == '0) ? S_TRANSMIT : S_FIRST_NUMBER;
                    end else begin
                        state_d = (payload == '0) ? S_OPCODE : S_DRAIN;
                    end
                end
            end
            S_FIRST_NUMBER: begin
                if (rx_fire) begin
                    acc_d[8*idx_q +: 8] = rx_data_i;
                    cnt_d = cnt_dec;
                    idx_d = idx_inc;
                    // A payload shorter than one word returns the partial little-endian value.
                    if (cnt_dec == '0) begin
                        idx_d   = '0;
                        state_d = S_TRANSMIT;
                    end else if (idx_last) begin
                        idx_d   = '0;
                        state_d = after_word(cnt_dec);
                    end
                end
            end
            S_RX_NUMBER: begin
                if (rx_fire) begin
                    opb_d[8*idx_q +: 8] = rx_data_i;
                    cnt_d = cnt_dec;
                    idx_d = idx_inc;
                    if (idx_last) begin
                        idx_d      = '0;
                        op_valid_d = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (op_fire) begin
                    op_valid_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (res_valid_i) begin
                    acc_d   = res_i;
                    state_d = after_word(cnt_q);
                end
            end
            S_ECHO: begin
                // tx_data_q doubles as the one-byte buffer; rx is only taken when it is empty.
                if (rx_fire) begin
                    tx_data_d  = rx_data_i;
                    tx_valid_d = 1'b1;
                    cnt_d      = cnt_dec;
                end else if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    if (cnt_q == '0) state_d = S_OPCODE;
                end
            end
            S_DRAIN: begin
                if (rx_fire) begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) state_d = is_arith ? S_TRANSMIT : S_OPCODE;
                end
            end
            S_TRANSMIT: begin
                if (!tx_valid_q) begin
                    tx_data_d  = acc_bytes[idx_q];
                    tx_valid_d = 1'b1;
                end else if (tx_fire) begin
                    if (idx_last) begin
                        tx_valid_d = 1'b0;
                        idx_d      = '0;
                        state_d    = S_OPCODE;
                    end else begin
                        tx_data_d = acc_bytes[idx_inc];
                        idx_d     = idx_inc;
                    end
                end
            end
            default: state_d = S_OPCODE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_OPCODE;
            opcode_q   <= '0;
            len_lo_q   <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            op_valid_q <= 1'b0;
            op_code_q  <= 2'b00;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            len_lo_q   <= len_lo_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            op_valid_q <= op_valid_d;
            op_code_q  <= op_code_d;
            started_q  <= started_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign op_valid_o = op_valid_q;
    assign op_code_o  = op_code_q;
    assign op_a_o     = acc_q;
    assign op_b_o     = opb_q;
    assign busy_o     = (state_q != S_OPCODE);

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Scoreboard bench for alu_packet_ctrl: expected ALU issues and tx bytes are queued as packets are built.
module tb_alu_packet_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [1:0]  op_code_o;
    logic [31:0] op_a_o;
    logic [31:0] op_b_o;
    logic        op_valid_o;
    logic        op_ready_i;
    logic [31:0] res_i;
    logic        res_valid_i;
    logic        busy_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  tx_exp_q [$];
    logic [65:0] iss_q [$];
    logic [7:0]  pkt_q [$];
    bit          bp_mode = 1'b0;
    bit          alu_hold = 1'b0;
    int          opv_cnt = 0;

    alu_packet_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .op_code_o   (op_code_o),
        .op_a_o      (op_a_o),
        .op_b_o      (op_b_o),
        .op_valid_o  (op_valid_o),
        .op_ready_i  (op_ready_i),
        .res_i       (res_i),
        .res_valid_i (res_valid_i),
        .busy_o      (busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Backpressure pattern for the transmitter: one ready cycle in three when bp_mode is set.
    initial begin
        int cyc = 0;
        tx_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            tx_ready_i = bp_mode ? (cyc % 3 == 0) : 1'b1;
        end
    end

    // tx monitor: every accepted byte is popped from the scoreboard; pending bytes must hold.
    initial begin
        bit         pend = 1'b0;
        logic [7:0] pend_data = 8'h00;
        logic [79:0] exp;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                pend = 1'b0;
            end else begin
                if (pend) check_val("tx_hold", 80'({tx_valid_o, tx_data_o}), 80'({1'b1, pend_data}));
                if (tx_valid_o && tx_ready_i) begin
                    exp = (tx_exp_q.size() > 0) ? 80'(tx_exp_q.pop_front()) : {80{1'b1}};
                    check_val("tx_byte", 80'(tx_data_o), exp);
                    $display("tx byte %02h", tx_data_o);
                    pend = 1'b0;
                end else begin
                    pend = tx_valid_o;
                end
                pend_data = tx_data_o;
            end
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (op_valid_o) opv_cnt++;
    end

    // Arithmetic unit model: random accept latency, result strobe 1-2 cycles after the handshake.
    initial begin
        logic [65:0] cap;
        logic [79:0] exp;
        logic [31:0] a, b, r;
        int          d;
        op_ready_i  = 1'b0;
        res_valid_i = 1'b0;
        res_i       = 32'h0;
        forever begin
            @(negedge clk_i);
            if (op_valid_o && !rst_i) begin
                cap = {op_code_o, op_a_o, op_b_o};
                d   = int'($urandom_range(0, 2));
                repeat (d) @(negedge clk_i);
                check_val("op_hold", 80'({op_valid_o, op_code_o, op_a_o, op_b_o}), 80'({1'b1, cap}));
                exp = (iss_q.size() > 0) ? 80'(iss_q.pop_front()) : {80{1'b1}};
                check_val("op_issue", 80'(cap), exp);
                $display("alu issue code=%0d a=%0h b=%0h", cap[65:64], cap[63:32], cap[31:0]);
                op_ready_i = 1'b1;
                @(posedge clk_i);
                #1;
                op_ready_i = 1'b0;
                a = cap[63:32];
                b = cap[31:0];
                case (cap[65:64])
                    2'b00:   r = a + b;
                    2'b01:   r = a * b;
                    2'b10:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                    default: r = 32'hDEAD_BEEF;
                endcase
                repeat (1 + int'($urandom_range(0, 1))) @(posedge clk_i);
                #1;
                if (!alu_hold) begin
                    res_i       = r;
                    res_valid_i = 1'b1;
                    @(posedge clk_i);
                    #1;
                    res_valid_i = 1'b0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk_i);
        while (!rx_ready_o && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (!rx_ready_o) check_val("rx_accept", 80'(rx_ready_o), 80'(1));
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic pkt_hdr(input logic [7:0] op, input logic [15:0] len);
        pkt_q.push_back(op);
        pkt_q.push_back(8'h00);
        pkt_q.push_back(len[7:0]);
        pkt_q.push_back(len[15:8]);
    endtask

    task automatic pkt_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) pkt_q.push_back(w[8*i +: 8]);
    endtask

    task automatic exp_tx_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) tx_exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic send_pkt(input string name);
        $display("send packet %s (%0d bytes)", name, pkt_q.size());
        for (int i = 0; i < pkt_q.size(); i++) send_byte(pkt_q[i]);
        pkt_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk_i);
        while ((tx_exp_q.size() != 0 || iss_q.size() != 0 || busy_o) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        check_val(tag, 80'(tx_exp_q.size() + iss_q.size() + int'(busy_o)), 80'(0));
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n;
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_val("rst_rx_ready", 80'(rx_ready_o), 80'(0));
        check_val("rst_tx_valid", 80'(tx_valid_o), 80'(0));
        check_val("rst_tx_data",  80'(tx_data_o),  80'(0));
        check_val("rst_op_valid", 80'(op_valid_o), 80'(0));
        check_val("rst_op_code",  80'(op_code_o),  80'(0));
        check_val("rst_op_a",     80'(op_a_o),     80'(0));
        check_val("rst_op_b",     80'(op_b_o),     80'(0));
        check_val("rst_busy",     80'(busy_o),     80'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_val("ready_at_release", 80'(rx_ready_o), 80'(0));
        @(negedge clk_i);
        check_val("ready_after_release", 80'(rx_ready_o), 80'(1));
        @(posedge clk_i);
        #1;

        // ADD 1 + 2
        pkt_hdr(8'hAD, 16'd12); pkt_word(32'd1); pkt_word(32'd2);
        iss_q.push_back({2'b00, 32'd1, 32'd2});
        exp_tx_word(32'd3);
        send_pkt("add");
        wait_idle("idle_add");

        // MUL 3 * 4 * 5
        pkt_hdr(8'h88, 16'h10); pkt_word(32'd3); pkt_word(32'd4); pkt_word(32'd5);
        iss_q.push_back({2'b01, 32'd3, 32'd4});
        iss_q.push_back({2'b01, 32'd12, 32'd5});
        exp_tx_word(32'h3C);
        send_pkt("mul3");
        wait_idle("idle_mul");

        // ECHO under backpressure
        bp_mode = 1'b1;
        pkt_hdr(8'hEC, 16'd7);
        pkt_q.push_back(8'h61); pkt_q.push_back(8'h62); pkt_q.push_back(8'h63);
        tx_exp_q.push_back(8'h61); tx_exp_q.push_back(8'h62); tx_exp_q.push_back(8'h63);
        send_pkt("echo_bp");
        wait_idle("idle_echo");
        bp_mode = 1'b0;

        // Unknown opcode drained silently, then an ADD 7 + 9
        pkt_hdr(8'h55, 16'd6); pkt_q.push_back(8'hAA); pkt_q.push_back(8'hBB);
        send_pkt("unknown");
        pkt_hdr(8'hAD, 16'd12); pkt_word(32'd7); pkt_word(32'd9);
        iss_q.push_back({2'b00, 32'd7, 32'd9});
        exp_tx_word(32'd16);
        send_pkt("add_after_unknown");
        wait_idle("idle_unknown");

        // ADD with two trailing bytes that must be discarded
        pkt_hdr(8'hAD, 16'd14); pkt_word(32'd5); pkt_word(32'd6);
        pkt_q.push_back(8'hFF); pkt_q.push_back(8'hFF);
        iss_q.push_back({2'b00, 32'd5, 32'd6});
        exp_tx_word(32'd11);
        send_pkt("add_trailing");
        wait_idle("idle_trailing");

        // Arithmetic with zero payload returns 0
        pkt_hdr(8'h88, 16'd4);
        exp_tx_word(32'd0);
        send_pkt("mul_empty");
        wait_idle("idle_mul_empty");

        // Length below header size: echo with nothing to return
        pkt_hdr(8'hEC, 16'd2);
        send_pkt("echo_short");
        wait_idle("idle_echo_short");

        // DIV 100 / 5
        opv_cnt = 0;
        pkt_hdr(8'hD1, 16'd12); pkt_word(32'd100); pkt_word(32'd5);
`ifdef ALU_DIV_EN
        iss_q.push_back({2'b10, 32'd100, 32'd5});
        exp_tx_word(32'h14);
        send_pkt("div");
        wait_idle("idle_div");
`else
        send_pkt("div_disabled");
        wait_idle("idle_div");
        check_val("div_no_issue", 80'(opv_cnt), 80'(0));
`endif

        // Reset while waiting for the ADD result: nothing may be transmitted
        alu_hold = 1'b1;
        pkt_hdr(8'hAD, 16'd12); pkt_word(32'd1); pkt_word(32'd2);
        iss_q.push_back({2'b00, 32'd1, 32'd2});
        send_pkt("add_reset");
        n = 0;
        while (iss_q.size() != 0 && n < 500) begin
            @(posedge clk_i);
            n++;
        end
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check_val("wait_busy", 80'(busy_o), 80'(1));
        check_val("wait_op_valid", 80'(op_valid_o), 80'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check_val("midrst_busy",     80'(busy_o),     80'(0));
        check_val("midrst_tx_valid", 80'(tx_valid_o), 80'(0));
        check_val("midrst_op_valid", 80'(op_valid_o), 80'(0));
        check_val("midrst_rx_ready", 80'(rx_ready_o), 80'(0));
        check_val("midrst_op_a",     80'(op_a_o),     80'(0));
        @(posedge clk_i);
        #1;
        rst_i    = 1'b0;
        alu_hold = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // ECHO after the reset
        pkt_hdr(8'hEC, 16'd6); pkt_q.push_back(8'h11); pkt_q.push_back(8'h22);
        tx_exp_q.push_back(8'h11); tx_exp_q.push_back(8'h22);
        send_pkt("echo_after_reset");
        wait_idle("idle_final");

        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        check_val("leftover_tx",  80'(tx_exp_q.size()), 80'(0));
        check_val("leftover_iss", 80'(iss_q.size()),    80'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_packet_ctrl.md
# alu_packet_ctrl

Packet sequencer between the UART byte streams and the shared 32-bit arithmetic unit on the icebreaker ALU design. It parses the request header (opcode, reserved byte, 16-bit length), assembles little-endian operands, and folds them through the arithmetic unit over a request/result handshake. It returns either the 4-byte result or the echoed payload on the TX byte stream. It is the only master of the arithmetic unit.

## Interface
- DATA_W, 32, operand/result width; multiple of 8
- LEN_W, 16, packet length field width
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  rx byte available
- rx_ready_o  out  1  controller accepts rx byte
- tx_data_o  out  8  byte to transmit
- tx_valid_o  out  1  tx byte valid
- tx_ready_i  in  1  transmitter accepts byte
- op_code_o  out  2  00 ADD, 01 MUL, 10 DIV
- op_a_o  out  DATA_W  accumulator operand
- op_b_o  out  DATA_W  new operand
- op_valid_o  out  1  operation request
- op_ready_i  in  1  arithmetic unit accepts request
- res_i  in  DATA_W  operation result
- res_valid_i  in  1  single-cycle result strobe
- busy_o  out  1  high in every state except OPCODE

## Operation
- Transfers occur on a rising edge where valid and ready are both high.
- Packet format: opcode (0xEC echo, 0xAD add, 0x88 mul, 0xD1 div), reserved byte (ignored), length LSB, length MSB. Length counts all bytes including the 4-byte header. Payload length is length-4; if length<4, payload length is 0.
- States: OPCODE, RESERVED, LENGTH_LSB, LENGTH_MSB, FIRST_NUMBER, RX_NUMBER, ISSUE, WAIT, ECHO, DRAIN, TRANSMIT.
- OPCODE → RESERVED → LENGTH_LSB → LENGTH_MSB: one accepted byte each. The opcode is latched in OPCODE.
- After LENGTH_MSB, the next state depends on opcode and payload:
  - Echo → ECHO.
  - Arithmetic → FIRST_NUMBER.
  - Unknown opcode → DRAIN.
  - Zero payload: echo → OPCODE; arithmetic → TRANSMIT with result 0; unknown → OPCODE.
- FIRST_NUMBER: shifts 4 bytes, LSB first, into the accumulator.
  - Next state is RX_NUMBER if ≥4 payload bytes remain, else TRANSMIT.
- RX_NUMBER: assembles the next word into op_b, then → ISSUE.
- ISSUE: op_valid_o held high with op_a_o=accumulator, op_b_o, and op_code_o stable. Leaves for WAIT on the op_ready_i edge.
- WAIT: on res_valid_i, accumulator ← res_i. Then → RX_NUMBER if ≥4 payload bytes remain, else TRANSMIT.
- Trailing payload bytes (<4): consumed and discarded before TRANSMIT.
- TRANSMIT: sends accumulator bytes LSB first, 4 bytes, then → OPCODE.
- ECHO: one-byte buffer. Accepts a byte only when the buffer is empty. Each payload byte is output unmodified, in order. Returns to OPCODE when the last byte has been sent.
- DRAIN: rx_ready_o=1 until the payload is consumed; no tx output.
- Arithmetic wraps modulo 2^DATA_W. Divide-by-zero results are whatever res_i returns; the controller does not inspect them.
- The payload counter is LEN_W bits and decrements once per accepted payload byte.

## Timing
- Reset values: rx_ready_o=0, tx_valid_o=0, tx_data_o=0, op_valid_o=0, op_code_o=0, op_a_o=0, op_b_o=0, busy_o=0. State=OPCODE; accumulator and counters are 0.
- rx_ready_o goes high the cycle after reset deasserts.
- rx_ready_o is 1 in OPCODE, RESERVED, LENGTH_*, FIRST_NUMBER, RX_NUMBER, and DRAIN. In ECHO it is 1 only when the buffer is empty. It is 0 in all other states.
- tx_valid_o and op_valid_o never drop, and their data never changes, until the handshake completes.
- ISSUE is entered the cycle after the 4th operand byte is accepted.
- First tx byte: tx_valid_o rises the cycle after entering TRANSMIT. Each tx byte occupies ≥1 cycle.
- Echo latency: an accepted byte appears on tx_data_o the following cycle.
- res_valid_i outside WAIT is ignored.
- rst_i mid-packet, including during ISSUE/WAIT/TRANSMIT, drops all valids next edge and returns to OPCODE; no partial result is sent.

## Configuration
- ALU_DIV_EN defined: opcode 0xD1 is accepted and issues op_code_o=10.
- ALU_DIV_EN undefined: 0xD1 is treated as an unknown opcode (DRAIN, no response), and op_code_o never takes the value 10.

## Test plan
- ADD: rx AD 00 0C 00 01 00 00 00 02 00 00 00 → one ADD issue with a=1, b=2; res model → tx 03 00 00 00.
- MUL, three words: AD→88, payload 3,4,5 (len 0x10) → two issues (3×4, then 12×5) → tx 3C 00 00 00.
- ECHO with backpressure: EC 00 07 00 61 62 63, tx_ready_i toggling 1-in-3 → tx exactly 61 62 63, no loss or duplication.
- Unknown opcode: 55 00 06 00 AA BB, then an ADD packet → no tx for the first; the second returns the correct sum.
- Reset mid-WAIT during an ADD packet → outputs at reset values, no tx. A following ECHO packet works.
- DIV: D1 00 0C 00 64 00 00 00 05 00 00 00 → with ALU_DIV_EN: tx 14 00 00 00. Without: drained, no tx, op_valid_o never asserted.
